// File: rtl/cpu_control_unit.sv
// Instruction sequencer for the 16-bit basic CPU: latches a 9-bit instruction in T0, then
// walks T1..T3 driving bus-mux select and register/ALU enables; outputs decode (state, IR) only.
module cpu_control_unit #(
   parameter int WORD = 16,
   parameter int K    = 9
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            run_i,
   input  logic [WORD-1:0] din_i,
   output logic [3:0]      select_o,
   output logic [7:0]      r_in_o,
   output logic            a_in_o,
   output logic            g_in_o,
   output logic            addsub_o,
   output logic            done_o,
   output logic            busy_o
);

   typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   // Mux inputs 0..K-2 are R0-R7, K-1 is G, K is din.
   localparam logic [3:0] SEL_G    = 4'(K - 1);
   localparam logic [3:0] SEL_DIN  = 4'(K);
   localparam logic [3:0] SEL_NONE = 4'b1111;

   state_t     state_q, state_d;
   logic [8:0] ir_q, ir_d;

   logic [2:0] opcode;
   logic [2:0] rx;
   logic [2:0] ry;
   logic [7:0] rx_onehot;
   logic       din_unused;

   assign opcode     = ir_q[8:6];
   assign rx         = ir_q[5:3];
   assign ry         = ir_q[2:0];
   assign rx_onehot  = 8'(1) << rx;
   assign din_unused = ^din_i[WORD-1:9];

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= T0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      select_o = SEL_NONE;
      r_in_o   = '0;
      a_in_o   = 1'b0;
      g_in_o   = 1'b0;
      addsub_o = 1'b0;
      done_o   = 1'b0;

      unique case (state_q)
         T0: begin
            if (run_i) begin
               ir_d    = din_i[8:0];
               state_d = T1;
            end
         end
         T1: begin
            case (opcode)
               OP_MV: begin
                  select_o = {1'b0, ry};
                  r_in_o   = rx_onehot;
                  done_o   = 1'b1;
                  state_d  = T0;
               end
               OP_MVI: begin
                  select_o = SEL_DIN;
                  r_in_o   = rx_onehot;
                  done_o   = 1'b1;
                  state_d  = T0;
               end
               OP_ADD, OP_SUB: begin
                  select_o = {1'b0, rx};
                  a_in_o   = 1'b1;
                  state_d  = T2;
               end
               default: begin
                  done_o  = 1'b1;
                  state_d = T0;
               end
            endcase
         end
         T2: begin
            select_o = {1'b0, ry};
            g_in_o   = 1'b1;
            addsub_o = ir_q[6];
            state_d  = T3;
         end
         T3: begin
            select_o = SEL_G;
            r_in_o   = rx_onehot;
            done_o   = 1'b1;
            state_d  = T0;
         end
         default: state_d = T0;
      endcase
   end

   assign busy_o = (state_q != T0);

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Instruction sequencer for the 16-bit basic CPU. It latches a 9-bit instruction from `din` when `run` is asserted, then steps a four-state machine (T0–T3). In each cycle it drives the bus multiplexer `select` code and the register, accumulator and ALU enables, so that each move or arithmetic instruction executes over the shared bus. It pulses `done` on the final cycle of every instruction.

## Interface
- `word`, 16: datapath width; only `din[8:0]` is used by this block.
- `k`, 9: number of bus-mux register inputs (R0–R7, G); fixes the `select` encoding below.

- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces state T0 and clears IR immediately.
- `run`  in  1  start request, sampled only in T0.
- `din`  in  `word`  data-in bus. Bits [8:0] form the instruction in T0; the full word is the immediate operand in T1 of `mvi`.
- `select`  out  4  bus-mux select: 0000–0111 = R0–R7, 1000 = G, 1001 = din, 1111 = bus cleared.
- `r_in`  out  8  one-hot write enable for R0–R7.
- `a_in`  out  1  load enable for the A (ALU operand) register.
- `g_in`  out  1  load enable for the G (ALU result) register.
- `addsub`  out  1  ALU op: 0 = add, 1 = subtract.
- `done`  out  1  one-cycle pulse on the last cycle of an instruction.
- `busy`  out  1  high whenever state ≠ T0.

## Operation
- Instruction format, IR[8:0] = III XXX YYY. III = opcode, XXX = destination/first operand Rx, YYY = source Ry.
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#din
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 1xx illegal
- State register: T0 (idle/fetch), T1, T2, T3. IR is a 9-bit register internal to this block.
- Outputs are combinational decodes of (state, IR) only. `run` and `din` never reach the outputs combinationally.
- Default value of every output, in every state unless overridden below: `select`=1111, `r_in`=0, `a_in`=0, `g_in`=0, `addsub`=0, `done`=0.
- T0:
  - If `run`=1: IR ← `din[8:0]`; next state T1.
  - Otherwise: hold T0; IR unchanged.
- T1:
  - mv: `select`={0,YYY}, `r_in`[XXX]=1, `done`=1; next T0.
  - mvi: `select`=1001, `r_in`[XXX]=1, `done`=1; next T0. The datapath holds the immediate on `din` during this cycle.
  - add/sub: `select`={0,XXX}, `a_in`=1; next T2.
  - illegal: `done`=1, no enables; next T0.
- T2 (add/sub only): `select`={0,YYY}, `g_in`=1, `addsub`=IR[6]; next T3.
- T3 (add/sub only): `select`=1000, `r_in`[XXX]=1, `done`=1; next T0.
- `run` is ignored in T1–T3. Holding `run` high gives back-to-back instructions: T0 is re-entered for exactly one cycle, and a new IR is captured on that cycle's edge.
- Rx = Ry is legal; operands are read before the write in every instruction.
- At most one bit of `r_in` is high in any cycle. `a_in`, `g_in` and `r_in` are never asserted in the same cycle.

## Timing
- Reset: asynchronous assertion takes effect within the same cycle.
  - state = T0, IR = 0, `busy` = 0.
  - All outputs at their defaults (`select`=1111, everything else 0).
  - Reset mid-instruction aborts the instruction; no further enables are issued.
- Deassertion of `reset` is synchronous to `clock` by the system; the first `run` is sampled on the next rising edge.
- Latency, with `run` sampled at edge N:
  - mv/mvi/illegal: `done` high during cycle N→N+1; destination written at edge N+1; 2 cycles total including T0.
  - add/sub: A loaded at edge N+1, G at edge N+2, Rx at edge N+3. `done` high during cycle N+2→N+3; 4 cycles total.
- `done` and `busy` are glitch-free state decodes. `done` is never high for two consecutive cycles.

## Test plan
- Reset, then `run`=0 for 5 cycles -> `select`=1111, all enables 0, `done`=0, `busy`=0 throughout.
- `din`=16'h001D (mv R3,R5), `run` pulsed one cycle -> T1: `select`=0101, `r_in`=8'h08, `done`=1; following cycle back to defaults.
- `din`=16'h0040 (mvi R0), then `din`=16'h1234 in T1 -> T1: `select`=1001, `r_in`=8'h01, `done`=1; bus mux delivers 16'h1234 into R0.
- `din`=16'h008A (add R1,R2) -> the three cycles after capture:
  - T1: `select`=0001, `a_in`=1
  - T2: `select`=0010, `g_in`=1, `addsub`=0
  - T3: `select`=1000, `r_in`=8'h02, `done`=1
- `din`=16'h00FF (sub R7,R7) with `run` held high -> T2 has `addsub`=1; T3 has `r_in`=8'h80; one T0 cycle follows; next instruction captured without a gap.
- `din`=16'h0100 (illegal) -> T1: `done`=1, `r_in`=0. Separately, assert `reset` during T2 of an add -> all outputs immediately at defaults, `busy`=0, no `r_in` pulse ever appears.
